csm_dual_port_core: RTL and testbench

//  Dual-port shared memory with per-address hold (lock) semaphores; the DUT driven by the CSM BFM.

---
 rtl/csm_pkg.sv | 26 ++
 rtl/csm_lock_table.sv | 94 +++++++++
 rtl/csm_dual_port_core.sv | 115 +++++++++++
 tb/tb_csm_dual_port_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csm_pkg.sv
// Shared types and defaults for the CSM dual-port shared memory with hold semaphores.
package csm_pkg;

    localparam int CSM_ADDR_W   = 3;
    localparam int CSM_DATA_W   = 8;
    localparam int CSM_ERRCNT_W = 16;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2,
        OP_HOLD  = 3'd3,
        OP_RELSE = 3'd4
    } csm_op_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } csm_port_e;

    // Ops that are refused when the address is held by the other port.
    function automatic logic op_needs_access(input logic [2:0] op);
        return (op == OP_READ) || (op == OP_WRITE) || (op == OP_HOLD);
    endfunction

endpackage

// File: rtl/csm_lock_table.sv
// Per-address hold semaphores: decides grant/err for both ports with port A evaluated first,
// and keeps the lock valid/owner state.
module csm_lock_table
    import csm_pkg::*;
#(
    parameter int ADDR_W = CSM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_vld_i,
    input  logic [2:0]        a_op_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic              b_vld_i,
    input  logic [2:0]        b_op_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic              a_grant_o,
    output logic              a_err_o,
    output logic              b_grant_o,
    output logic              b_err_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] lock_v_q;
    csm_port_e        lock_own_q [DEPTH];

    logic      a_ok;
    logic      b_ok;
    logic      a_v;
    csm_port_e a_own;
    logic      b_v_mid;
    csm_port_e b_own_mid;

    always_comb begin
        a_v       = lock_v_q[a_addr_i];
        a_own     = lock_own_q[a_addr_i];
        a_ok      = 1'b0;
        if (a_vld_i) begin
            if (op_needs_access(a_op_i)) begin
                a_ok = !(a_v && (a_own != PORT_A));
            end else if (a_op_i == OP_RELSE) begin
                a_ok = a_v && (a_own == PORT_A);
            end
        end

        // B sees the lock state as it stands after A's hold/release this cycle.
        b_v_mid   = lock_v_q[b_addr_i];
        b_own_mid = lock_own_q[b_addr_i];
        if (a_ok && (a_addr_i == b_addr_i)) begin
            if (a_op_i == OP_HOLD) begin
                b_v_mid   = 1'b1;
                b_own_mid = PORT_A;
            end else if (a_op_i == OP_RELSE) begin
                b_v_mid   = 1'b0;
            end
        end

        b_ok = 1'b0;
        if (b_vld_i) begin
            if (op_needs_access(b_op_i)) begin
                b_ok = !(b_v_mid && (b_own_mid != PORT_B));
            end else if (b_op_i == OP_RELSE) begin
                b_ok = b_v_mid && (b_own_mid == PORT_B);
            end
        end
    end

    assign a_grant_o = a_ok;
    assign a_err_o   = a_vld_i && !a_ok;
    assign b_grant_o = b_ok;
    assign b_err_o   = b_vld_i && !b_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_v_q   <= '0;
            lock_own_q <= '{default: PORT_A};
        end else begin
            if (a_ok && (a_op_i == OP_HOLD)) begin
                lock_v_q[a_addr_i]   <= 1'b1;
                lock_own_q[a_addr_i] <= PORT_A;
            end else if (a_ok && (a_op_i == OP_RELSE)) begin
                lock_v_q[a_addr_i]   <= 1'b0;
            end
            // B's update lands after A's so release-then-hold on one address ends owned by B.
            if (b_ok && (b_op_i == OP_HOLD)) begin
                lock_v_q[b_addr_i]   <= 1'b1;
                lock_own_q[b_addr_i] <= PORT_B;
            end else if (b_ok && (b_op_i == OP_RELSE)) begin
                lock_v_q[b_addr_i]   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/csm_dual_port_core.sv
// Dual-port shared memory with per-address hold locks: memory array, write-collision
// resolution, registered per-port responses and saturating error counters.
module csm_dual_port_core
    import csm_pkg::*;
#(
    parameter int ADDR_W   = CSM_ADDR_W,
    parameter int DATA_W   = CSM_DATA_W,
    parameter int ERRCNT_W = CSM_ERRCNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_req,
    input  logic [2:0]          a_op,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic                a_ack,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_err,
    output logic [ERRCNT_W-1:0] a_errcnt,
    input  logic                b_req,
    input  logic [2:0]          b_op,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic                b_ack,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_err,
    output logic [ERRCNT_W-1:0] b_errcnt
);

    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                a_ack_q, b_ack_q;
    logic                a_err_q, b_err_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
    logic [ERRCNT_W-1:0] a_errcnt_q, b_errcnt_q;

    logic a_vld, b_vld;
    logic a_grant, b_grant;
    logic a_lt_err, b_lt_err;
    logic a_wr_d, b_wr_d, a_rd_d, b_rd_d;
    logic collide;
    logic a_err_d, b_err_d;

    assign a_vld = a_req && (a_op != OP_NOP);
    assign b_vld = b_req && (b_op != OP_NOP);

    csm_lock_table #(
        .ADDR_W (ADDR_W)
    ) u_lock (
        .clk       (clk),
        .reset     (reset),
        .a_vld_i   (a_vld),
        .a_op_i    (a_op),
        .a_addr_i  (a_addr),
        .b_vld_i   (b_vld),
        .b_op_i    (b_op),
        .b_addr_i  (b_addr),
        .a_grant_o (a_grant),
        .a_err_o   (a_lt_err),
        .b_grant_o (b_grant),
        .b_err_o   (b_lt_err)
    );

    always_comb begin
        a_rd_d  = a_grant && (a_op == OP_READ);
        b_rd_d  = b_grant && (b_op == OP_READ);
        a_wr_d  = a_grant && (a_op == OP_WRITE);
        // Two allowed writes to one address: A's data wins and B is refused.
        collide = a_wr_d && b_grant && (b_op == OP_WRITE) && (a_addr == b_addr);
        b_wr_d  = b_grant && (b_op == OP_WRITE) && !collide;
        a_err_d = a_lt_err;
        b_err_d = b_lt_err || collide;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_errcnt_q <= '0;
            b_errcnt_q <= '0;
        end else begin
            a_ack_q <= a_vld;
            b_ack_q <= b_vld;
            a_err_q <= a_err_d;
            b_err_q <= b_err_d;
            // Reads take the pre-edge array contents, so a same-cycle write is not visible.
            if (a_rd_d) a_rdata_q <= mem_q[a_addr];
            if (b_rd_d) b_rdata_q <= mem_q[b_addr];
            if (a_wr_d) mem_q[a_addr] <= a_wdata;
            if (b_wr_d) mem_q[b_addr] <= b_wdata;
            if (a_err_d) a_errcnt_q <= sat_inc(a_errcnt_q);
            if (b_err_d) b_errcnt_q <= sat_inc(b_errcnt_q);
        end
    end

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_err    = a_err_q;
    assign b_err    = b_err_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign a_errcnt = a_errcnt_q;
    assign b_errcnt = b_errcnt_q;

endmodule

// File: tb/tb_csm_dual_port_core.sv
// Bench for csm_dual_port_core: directed scenarios plus randomized traffic against a
// sequential rule-based model of the shared memory and its locks.
module tb_csm_dual_port_core;

    localparam logic [2:0] NOP = 3'd0, RD = 3'd1, WR = 3'd2, HLD = 3'd3, REL = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req;
    logic [2:0]  a_op, b_op;
    logic [2:0]  a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_ack, b_ack, a_err, b_err;
    logic [7:0]  a_rdata, b_rdata;
    logic [15:0] a_errcnt, b_errcnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: memory, lock valid, lock owner (0 = A, 1 = B), expected outputs.
    logic [7:0] m_mem [8];
    bit         m_lv  [8];
    bit         m_lo  [8];
    bit         e_aack, e_back, e_aerr, e_berr;
    logic [7:0] e_ard, e_brd;
    int         e_aec, e_bec;

    always #5 clk = ~clk;

    csm_dual_port_core dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .a_op     (a_op),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_rdata  (a_rdata),
        .a_err    (a_err),
        .a_errcnt (a_errcnt),
        .b_req    (b_req),
        .b_op     (b_op),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_rdata  (b_rdata),
        .b_err    (b_err),
        .b_errcnt (b_errcnt)
    );

    // Drive one cycle of requests, advance the model by the stated rules, then sample the DUT.
    task automatic drive(input bit rst,
                         input bit ar, input logic [2:0] aop, input int ai, input logic [7:0] awd,
                         input bit br, input logic [2:0] bop, input int bi, input logic [7:0] bwd);
        bit a_act, b_act, a_ok, b_ok;
        reset = rst;
        a_req = ar; a_op = aop; a_addr = 3'(ai); a_wdata = awd;
        b_req = br; b_op = bop; b_addr = 3'(bi); b_wdata = bwd;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m_mem[i] = 8'h00; m_lv[i] = 0; m_lo[i] = 0; end
            e_aack = 0; e_back = 0; e_aerr = 0; e_berr = 0;
            e_ard = 8'h00; e_brd = 8'h00; e_aec = 0; e_bec = 0;
        end else begin
            a_act = ar && (aop != NOP);
            b_act = br && (bop != NOP);
            a_ok = 0;
            if (a_act) begin
                if (aop == RD || aop == WR || aop == HLD) a_ok = !(m_lv[ai] && m_lo[ai]);
                else if (aop == REL) a_ok = m_lv[ai] && !m_lo[ai];
            end
            if (a_ok && aop == HLD) begin m_lv[ai] = 1; m_lo[ai] = 0; end
            if (a_ok && aop == REL) m_lv[ai] = 0;
            b_ok = 0;
            if (b_act) begin
                if (bop == RD || bop == WR || bop == HLD) b_ok = !(m_lv[bi] && !m_lo[bi]);
                else if (bop == REL) b_ok = m_lv[bi] && m_lo[bi];
            end
            if (b_ok && bop == WR && a_ok && aop == WR && ai == bi) b_ok = 0;
            if (b_ok && bop == HLD) begin m_lv[bi] = 1; m_lo[bi] = 1; end
            if (b_ok && bop == REL) m_lv[bi] = 0;
            if (a_ok && aop == RD) e_ard = m_mem[ai];
            if (b_ok && bop == RD) e_brd = m_mem[bi];
            if (a_ok && aop == WR) m_mem[ai] = awd;
            if (b_ok && bop == WR) m_mem[bi] = bwd;
            e_aack = a_act; e_back = b_act;
            e_aerr = a_act && !a_ok; e_berr = b_act && !b_ok;
            if (e_aerr && e_aec < 65535) e_aec++;
            if (e_berr && e_bec < 65535) e_bec++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, NOP, 0, 8'h00, 0, NOP, 0, 8'h00);
    endtask

    task automatic test_reset();
        drive(1, 1, WR, 3, 8'h77, 1, HLD, 3, 8'h00);
        drive(1, 1, WR, 3, 8'h77, 1, HLD, 3, 8'h00);
        n_vec++; if ({a_ack, b_ack, a_err, b_err} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_acks got=%b want=0000", {a_ack, b_ack, a_err, b_err}); end
        n_vec++; if ({a_rdata, b_rdata, a_errcnt, b_errcnt} !== 48'h0) begin n_bad++;
            $display("FAIL reset_data got=%h want=0", {a_rdata, b_rdata, a_errcnt, b_errcnt}); end
        idle();
        n_vec++; if (a_ack !== 1'b0) begin n_bad++;
            $display("FAIL dropped_req_on_reset a_ack got=%b want=0", a_ack); end
        drive(0, 0, WR, 3, 8'h12, 1, NOP, 3, 8'h00);
        n_vec++; if ({a_ack, b_ack} !== 2'b00) begin n_bad++;
            $display("FAIL noack_nop got=%b want=00", {a_ack, b_ack}); end
    endtask

    task automatic test_write_read();
        drive(0, 1, WR, 3, 8'hA5, 0, NOP, 0, 8'h00);
        n_vec++; if ({a_ack, a_err} !== 2'b10) begin n_bad++;
            $display("FAIL a_write ack/err got=%b want=10", {a_ack, a_err}); end
        drive(0, 0, NOP, 0, 8'h00, 1, RD, 3, 8'h00);
        n_vec++; if ({b_ack, b_err, b_rdata} !== {2'b10, 8'hA5}) begin n_bad++;
            $display("FAIL b_read ack/err/rdata got=%b/%b/%h want=1/0/a5", b_ack, b_err, b_rdata); end
        n_vec++; if (a_ack !== 1'b0) begin n_bad++;
            $display("FAIL single_ack a_ack got=%b want=0", a_ack); end
    endtask

    task automatic test_hold_block();
        drive(0, 1, HLD, 5, 8'h00, 0, NOP, 0, 8'h00);
        n_vec++; if ({a_ack, a_err} !== 2'b10) begin n_bad++;
            $display("FAIL a_hold got=%b want=10", {a_ack, a_err}); end
        drive(0, 0, NOP, 0, 8'h00, 1, WR, 5, 8'hFF);
        n_vec++; if ({b_ack, b_err, b_errcnt} !== {2'b11, 16'd1}) begin n_bad++;
            $display("FAIL b_write_blocked got=%b/%b/%0d want=1/1/1", b_ack, b_err, b_errcnt); end
        drive(0, 1, RD, 5, 8'h00, 0, NOP, 0, 8'h00);
        n_vec++; if ({a_err, a_rdata} !== {1'b0, 8'h00}) begin n_bad++;
            $display("FAIL mem5_unchanged got=%b/%h want=0/00", a_err, a_rdata); end
        drive(0, 1, WR, 5, 8'h11, 0, NOP, 0, 8'h00);
        n_vec++; if ({a_ack, a_err} !== 2'b10) begin n_bad++;
            $display("FAIL owner_write got=%b want=10", {a_ack, a_err}); end
        drive(0, 1, RD, 5, 8'h00, 0, NOP, 0, 8'h00);
        n_vec++; if (a_rdata !== 8'h11) begin n_bad++;
            $display("FAIL owner_readback got=%h want=11", a_rdata); end
        drive(0, 1, REL, 5, 8'h00, 0, NOP, 0, 8'h00);
    endtask

    task automatic test_same_cycle_hold();
        drive(0, 1, HLD, 2, 8'h00, 1, RD, 2, 8'h00);
        n_vec++; if ({a_ack, a_err, b_ack, b_err} !== 4'b1011) begin n_bad++;
            $display("FAIL hold_vs_read got=%b want=1011", {a_ack, a_err, b_ack, b_err}); end
        drive(0, 1, REL, 2, 8'h00, 0, NOP, 0, 8'h00);
        n_vec++; if ({a_ack, a_err} !== 2'b10) begin n_bad++;
            $display("FAIL a_relse got=%b want=10", {a_ack, a_err}); end
        drive(0, 0, NOP, 0, 8'h00, 1, RD, 2, 8'h00);
        n_vec++; if ({b_ack, b_err} !== 2'b10) begin n_bad++;
            $display("FAIL read_after_relse got=%b want=10", {b_ack, b_err}); end
        drive(0, 1, HLD, 0, 8'h00, 1, HLD, 0, 8'h00);
        n_vec++; if ({a_err, b_err} !== 2'b01) begin n_bad++;
            $display("FAIL both_hold got=%b want=01", {a_err, b_err}); end
        drive(0, 1, REL, 0, 8'h00, 1, HLD, 0, 8'h00);
        n_vec++; if ({a_err, b_err} !== 2'b00) begin n_bad++;
            $display("FAIL relse_then_hold got=%b want=00", {a_err, b_err}); end
        drive(0, 1, RD, 0, 8'h00, 1, REL, 0, 8'h00);
        n_vec++; if ({a_err, b_err} !== 2'b10) begin n_bad++;
            $display("FAIL b_owns_after_handover got=%b want=10", {a_err, b_err}); end
    endtask

    task automatic test_collision();
        drive(0, 1, WR, 7, 8'h99, 0, NOP, 0, 8'h00);
        drive(0, 1, WR, 7, 8'h00, 1, WR, 7, 8'h3C);
        n_vec++; if ({a_err, b_ack, b_err} !== 3'b011) begin n_bad++;
            $display("FAIL write_collision got=%b want=011", {a_err, b_ack, b_err}); end
        drive(0, 0, NOP, 0, 8'h00, 1, RD, 7, 8'h00);
        n_vec++; if (b_rdata !== 8'h00) begin n_bad++;
            $display("FAIL mem7_a_wins got=%h want=00", b_rdata); end
        drive(0, 1, WR, 1, 8'h55, 1, RD, 1, 8'h00);
        n_vec++; if ({b_err, b_rdata} !== {1'b0, 8'h00}) begin n_bad++;
            $display("FAIL read_before_write got=%b/%h want=0/00", b_err, b_rdata); end
        drive(0, 1, RD, 1, 8'h00, 1, WR, 1, 8'h66);
        n_vec++; if (a_rdata !== 8'h55) begin n_bad++;
            $display("FAIL read_before_write_swapped got=%h want=55", a_rdata); end
        drive(0, 1, WR, 4, 8'hC3, 0, NOP, 0, 8'h00);
        n_vec++; if (a_rdata !== 8'h55) begin n_bad++;
            $display("FAIL rdata_held_on_write got=%h want=55", a_rdata); end
    endtask

    task automatic test_relse();
        drive(0, 0, NOP, 0, 8'h00, 1, REL, 4, 8'h00);
        n_vec++; if ({b_ack, b_err} !== 2'b11) begin n_bad++;
            $display("FAIL relse_free got=%b want=11", {b_ack, b_err}); end
        drive(0, 1, HLD, 4, 8'h00, 0, NOP, 0, 8'h00);
        drive(0, 1, HLD, 4, 8'h00, 0, NOP, 0, 8'h00);
        n_vec++; if ({a_ack, a_err} !== 2'b10) begin n_bad++;
            $display("FAIL rehold got=%b want=10", {a_ack, a_err}); end
        drive(0, 0, NOP, 0, 8'h00, 1, REL, 4, 8'h00);
        n_vec++; if (b_err !== 1'b1) begin n_bad++;
            $display("FAIL relse_foreign got=%b want=1", b_err); end
        drive(0, 0, NOP, 0, 8'h00, 1, RD, 4, 8'h00);
        n_vec++; if ({b_err, b_rdata} !== {1'b1, 8'h00}) begin n_bad++;
            $display("FAIL lock_still_a got=%b/%h want=1/00", b_err, b_rdata); end
        drive(0, 1, REL, 4, 8'h00, 0, NOP, 0, 8'h00);
    endtask

    task automatic test_reset_outstanding();
        drive(0, 1, WR, 3, 8'hEE, 0, NOP, 0, 8'h00);
        drive(1, 1, HLD, 6, 8'h00, 0, NOP, 0, 8'h00);
        n_vec++; if ({a_ack, a_err, b_errcnt} !== 18'h0) begin n_bad++;
            $display("FAIL reset_discards got=%b/%b/%0d want=0/0/0", a_ack, a_err, b_errcnt); end
        drive(0, 0, NOP, 0, 8'h00, 1, HLD, 6, 8'h00);
        n_vec++; if ({b_ack, b_err} !== 2'b10) begin n_bad++;
            $display("FAIL hold_after_reset got=%b want=10", {b_ack, b_err}); end
        drive(0, 0, NOP, 0, 8'h00, 1, RD, 3, 8'h00);
        n_vec++; if ({b_err, b_rdata} !== {1'b0, 8'h00}) begin n_bad++;
            $display("FAIL mem_cleared got=%b/%h want=0/00", b_err, b_rdata); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) < 2),
                  1'($urandom), 3'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom), 3'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 8'($urandom));
            n_vec++; if ({a_ack, a_err, b_ack, b_err} !== {e_aack, e_aerr, e_back, e_berr}) begin n_bad++;
                $display("FAIL rnd_flags n=%0d got=%b want=%b", n, {a_ack, a_err, b_ack, b_err},
                         {e_aack, e_aerr, e_back, e_berr}); end
            n_vec++; if ({a_rdata, b_rdata} !== {e_ard, e_brd}) begin n_bad++;
                $display("FAIL rnd_rdata n=%0d got=%h/%h want=%h/%h", n, a_rdata, b_rdata, e_ard, e_brd); end
            n_vec++; if ({a_errcnt, b_errcnt} !== {16'(e_aec), 16'(e_bec)}) begin n_bad++;
                $display("FAIL rnd_errcnt n=%0d got=%0d/%0d want=%0d/%0d", n, a_errcnt, b_errcnt, e_aec, e_bec); end
        end
    endtask

    task automatic test_errcnt_sat();
        drive(1, 0, NOP, 0, 8'h00, 0, NOP, 0, 8'h00);
        for (int n = 0; n < 65535; n++) drive(0, 0, NOP, 0, 8'h00, 1, REL, 0, 8'h00);
        n_vec++; if (b_errcnt !== 16'hFFFF || e_bec != 65535) begin n_bad++;
            $display("FAIL errcnt_reach_max got=%h want=ffff", b_errcnt); end
        for (int n = 0; n < 3; n++) drive(0, 0, NOP, 0, 8'h00, 1, REL, 0, 8'h00);
        n_vec++; if ({b_err, b_errcnt} !== {1'b1, 16'hFFFF}) begin n_bad++;
            $display("FAIL errcnt_saturate got=%b/%h want=1/ffff", b_err, b_errcnt); end
        n_vec++; if (a_errcnt !== 16'h0000) begin n_bad++;
            $display("FAIL errcnt_a_untouched got=%h want=0000", a_errcnt); end
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_op = NOP; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_op = NOP; b_addr = '0; b_wdata = '0;
        test_reset();
        test_write_read();
        test_hold_block();
        test_same_cycle_hold();
        test_collision();
        test_relse();
        test_reset_outstanding();
        test_random();
        test_errcnt_sat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
